// File: rtl/alu_result_buffer.sv
// Registered FIFO that holds ALU logical-unit results with their destination tag
// and the zero/all-ones flags taken at capture, until the write port accepts them.
module alu_result_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_ones,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             zero_q [DEPTH];
  logic             ones_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Acceptance looks only at occupancy, so a pop never frees a slot early.
  assign in_ready  = !rst && (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= in_result;
      tag_q[wr_ptr]  <= in_tag;
      zero_q[wr_ptr] <= (in_result == '0);
      ones_q[wr_ptr] <= &in_result;
    end
  end

  assign out_result = out_valid ? data_q[rd_ptr] : '0;
  assign out_tag    = out_valid ? tag_q[rd_ptr]  : '0;
  assign out_zero   = out_valid && zero_q[rd_ptr];
  assign out_ones   = out_valid && ones_q[rd_ptr];

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed plan plus random traffic
// checked against a queue model of the buffer.
module tb_alu_result_buffer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_result = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_ones;
  logic [2:0]       count;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_ones(out_ones),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] t;
    r = '0;
    t = '0;
    if (q.size() != 0) begin
      r = q[0].res;
      t = q[0].tag;
    end
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("out_result", out_result, r);
    check("out_tag", 64'(out_tag), 64'(t));
    check("out_zero", 64'(out_zero), 64'(q.size() != 0 && r == 0));
    check("out_ones", 64'(out_ones), 64'(q.size() != 0 && r == '1));
  endtask

  // Drive one cycle from a falling edge; model the edge; check at next fall.
  task automatic step(logic v, logic [WIDTH-1:0] d, logic [TAG_W-1:0] t,
                      logic ordy);
    int sz;
    ent_t e;
    in_valid  = v;
    in_result = d;
    in_tag    = t;
    out_ready = ordy;
    @(posedge clk);
    sz = q.size();
    if (ordy && sz > 0) void'(q.pop_front());
    if (v && sz < DEPTH) begin
      e.res = d;
      e.tag = t;
      q.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k == 1) return '1;
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = 64'hAAAAAAAAAAAAAAAA;
    b = 64'h5555555555555555;

    // reset held with in_valid asserted
    rst = 1'b1;
    in_valid = 1'b1;
    in_result = '1;
    in_tag = 5'd1;
    repeat (3) begin
      @(negedge clk);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", out_result, 64'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    compare_all();

    // flags
    step(1'b1, a & b, 5'd3, 1'b0);
    check("flag_zero_first", 64'(out_zero), 64'd1);
    check("flag_tag_first", 64'(out_tag), 64'd3);
    step(1'b1, a, 5'd7, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    check("flag_tag_second", 64'(out_tag), 64'd7);
    check("flag_zero_second", 64'(out_zero), 64'd0);
    check("flag_ones_second", 64'(out_ones), 64'd0);
    step(1'b1, '1, 5'd8, 1'b1);
    check("flag_ones", 64'(out_ones), 64'd1);
    step(1'b0, '0, '0, 1'b1);
    check("flag_empty", 64'(out_valid), 64'd0);

    // fill past full, then drain
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, {$urandom, $urandom}, 5'(i), 1'b0);
      if (i == 4) check("full_in_ready", 64'(in_ready), 64'd0);
    end
    check("full_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_tag", 64'(out_tag), 64'(i));
      step(1'b0, '0, '0, 1'b1);
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1);

    // sustained push+pop across pointer wraps
    for (int i = 0; i < 20; i++) begin
      if (i > 0) check("wrap_tag", 64'(out_tag), 64'(i - 1));
      step(1'b1, rnd_data(), 5'(i), 1'b1);
      check("wrap_count", 64'(count), 64'd1);
    end
    step(1'b0, '0, '0, 1'b1);

    // full with simultaneous pop rejects the push
    for (int i = 0; i < 4; i++) step(1'b1, rnd_data(), 5'(10 + i), 1'b0);
    step(1'b1, rnd_data(), 5'd20, 1'b1);
    check("fullpop_count", 64'(count), 64'd3);
    step(1'b1, rnd_data(), 5'd20, 1'b0);
    check("fullpop_refill", 64'(count), 64'd4);
    step(1'b0, '0, '0, 1'b1);

    // asynchronous reset mid-stream
    check("pre_rst_count", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("async_count", 64'(count), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_out_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_all();
    step(1'b1, rnd_data(), 5'd9, 1'b0);
    check("post_rst_tag", 64'(out_tag), 64'd9);
    step(1'b0, '0, '0, 1'b1);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_data(), 5'($urandom),
           1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
